// File: rtl/ma_pkg.sv
// Shared encodings and helpers for the RV32I memory-access stage:
// load/store size codes, byte-enable generation, store lane alignment, load extension.
package ma_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

  // Byte enables of an aligned access; funct3[1:0] carries the size.
  function automatic logic [3:0] be_align(input logic [2:0] code, input logic [1:0] off);
    case (code[1:0])
      2'b00:   be_align = 4'b0001 << off;
      2'b01:   be_align = off[1] ? 4'b1100 : 4'b0011;
      default: be_align = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [2:0] code, input logic [31:0] data);
    case (code[1:0])
      2'b00:   store_align = {4{data[7:0]}};
      2'b01:   store_align = {2{data[15:0]}};
      default: store_align = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] code, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (code)
      LDST_B:  load_extend = {{24{sh[7]}}, sh[7:0]};
      LDST_BU: load_extend = {24'h0, sh[7:0]};
      LDST_H:  load_extend = {{16{sh[15]}}, sh[15:0]};
      LDST_HU: load_extend = {16'h0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/ma_store_buffer.sv
// Posted store buffer: circular FIFO that drains its head every cycle it is non-empty,
// with byte-granular, youngest-wins forwarding to a load word address.
module ma_store_buffer
  import ma_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_fwd_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_head_addr,
  output logic [31:0]   o_head_data,
  output logic [3:0]    o_head_be,
  output logic [31:0]   o_fwd_data,
  output logic [3:0]    o_fwd_mask
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]     r_head, r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]   r_addr [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [3:0]      r_be   [DEPTH];
  logic [PW:0]     w_count;
  logic            w_pop;

  assign w_count     = r_tail - r_head;
  assign o_empty     = (w_count == '0);
  assign o_full      = (w_count == (PW+1)'(DEPTH));
  assign w_pop       = !o_empty;
  assign o_head_addr = r_addr[r_head[PW-1:0]];
  assign o_head_data = r_data[r_head[PW-1:0]];
  assign o_head_be   = r_be[r_head[PW-1:0]];

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head[PW-1:0]] <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      if (i_push) begin
        r_valid[r_tail[PW-1:0]] <= 1'b1;
        r_tail                  <= r_tail + 1'b1;
      end
    end
  end

  // NOTE: payload storage carries no reset; r_valid alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail[PW-1:0]] <= i_addr;
      r_data[r_tail[PW-1:0]] <= i_data;
      r_be[r_tail[PW-1:0]]   <= i_be;
    end
  end

  // Walk from the oldest slot to the youngest so later matches overwrite earlier ones.
  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    logic [PW-1:0] idx;
    o_fwd_data = '0;
    o_fwd_mask = '0;
    idx        = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = r_tail[PW-1:0] - PW'(k);
      if (r_valid[idx] && (r_addr[idx] == i_fwd_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[idx][b]) begin
            o_fwd_data[8*b +: 8] = r_data[idx][8*b +: 8];
            o_fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ma_stage_sbuf.sv
// RV32I memory-access stage with a posted store buffer, store-to-load forwarding,
// in-stage load alignment/extension, misalignment detection and an ordered IO region.
module ma_stage_sbuf
  import ma_pkg::*;
#(
  parameter int         DWIDTH   = 11,
  parameter int         SB_DEPTH = 4,
  parameter logic [1:0] IO_TAG   = IO_TAG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic [4:0]        rd_adr_ma,
  input  logic [31:0]       rd_data_ma,
  input  logic              wbk_rd_reg_ma,
  input  logic [31:0]       st_data_ma,
  input  logic              rst_pipe_ma,
  output logic              stall_req,
  output logic              cmd_ld_wb,
  output logic [2:0]        ld_code_wb,
  output logic [4:0]        rd_adr_wb,
  output logic [31:0]       rd_data_wb,
  output logic              wbk_rd_reg_wb,
  output logic [31:0]       ld_data_wb,
  output logic              misalign_wb,
  output logic              ram_ren,
  output logic [DWIDTH-1:0] ram_radr,
  input  logic [31:0]       ram_rdata,
  output logic              ram_wen,
  output logic [DWIDTH-1:0] ram_wadr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              io_we,
  output logic              io_re,
  output logic [13:0]       io_wadr,
  output logic [13:0]       io_radr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata
);

  logic [1:0]        w_off;
  logic [DWIDTH-1:0] w_waddr;
  logic w_is_io, w_misalign, w_mem_st, w_mem_ld, w_io_op, w_accept;
  logic w_sb_full, w_sb_empty;
  logic [31:0] w_fwd_data, w_merged;
  logic [3:0]  w_fwd_mask;

  logic        r_io_ld;
  logic [31:0] r_fwd_data;
  logic [3:0]  r_fwd_mask;

  assign w_off      = rd_data_ma[1:0];
  assign w_waddr    = rd_data_ma[DWIDTH+1:2];
  assign w_is_io    = (rd_data_ma[31:30] == IO_TAG);
  assign w_misalign = (cmd_ld_ma || cmd_st_ma) &&
                      (((ldst_code_ma[1:0] == 2'b01) && w_off[0]) ||
                       ((ldst_code_ma[1:0] == 2'b10) && (w_off != 2'b00)));
  assign w_mem_st   = cmd_st_ma && !w_is_io && !w_misalign;
  assign w_mem_ld   = cmd_ld_ma && !w_is_io && !w_misalign;
  assign w_io_op    = (cmd_ld_ma || cmd_st_ma) && w_is_io && !w_misalign;

  // IO waits for an empty buffer so it is never reordered ahead of posted stores.
  assign stall_req = (w_mem_st && w_sb_full) || (w_io_op && !w_sb_empty);
  assign w_accept  = !stall_req && !rst_pipe_ma;

  ma_store_buffer #(.AW(DWIDTH), .DEPTH(SB_DEPTH)) u_sbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_mem_st && w_accept),
    .i_addr      (w_waddr),
    .i_data      (store_align(ldst_code_ma, st_data_ma)),
    .i_be        (be_align(ldst_code_ma, w_off)),
    .i_fwd_addr  (w_waddr),
    .o_full      (w_sb_full),
    .o_empty     (w_sb_empty),
    .o_head_addr (ram_wadr),
    .o_head_data (ram_wdata),
    .o_head_be   (ram_be),
    .o_fwd_data  (w_fwd_data),
    .o_fwd_mask  (w_fwd_mask)
  );

  assign ram_wen  = !w_sb_empty;
  assign ram_ren  = w_mem_ld && w_accept;
  assign ram_radr = w_waddr;
  assign io_we    = w_io_op && cmd_st_ma && (ldst_code_ma == LDST_W) && w_accept;
  assign io_re    = w_io_op && cmd_ld_ma && w_accept;
  assign io_wadr  = rd_data_ma[15:2];
  assign io_radr  = rd_data_ma[15:2];
  assign io_wdata = st_data_ma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ld_wb     <= 1'b0;
      ld_code_wb    <= '0;
      rd_adr_wb     <= '0;
      rd_data_wb    <= '0;
      wbk_rd_reg_wb <= 1'b0;
      misalign_wb   <= 1'b0;
      r_io_ld       <= 1'b0;
      r_fwd_data    <= '0;
      r_fwd_mask    <= '0;
    end else if (rst_pipe_ma) begin
      cmd_ld_wb     <= 1'b0;
      ld_code_wb    <= '0;
      rd_adr_wb     <= '0;
      rd_data_wb    <= '0;
      wbk_rd_reg_wb <= 1'b0;
      misalign_wb   <= 1'b0;
      r_io_ld       <= 1'b0;
      r_fwd_data    <= '0;
      r_fwd_mask    <= '0;
    end else begin
      // A stalled op is still held in EX, so WB sees a bubble this cycle.
      cmd_ld_wb     <= cmd_ld_ma && !stall_req;
      ld_code_wb    <= ldst_code_ma;
      rd_adr_wb     <= rd_adr_ma;
      rd_data_wb    <= rd_data_ma;
      wbk_rd_reg_wb <= wbk_rd_reg_ma && !stall_req && !w_misalign;
      misalign_wb   <= w_misalign;
      r_io_ld       <= io_re;
      r_fwd_data    <= w_fwd_data;
      r_fwd_mask    <= w_mem_ld ? w_fwd_mask : 4'b0000;
    end
  end

  always_comb begin
    w_merged = ram_rdata;
    if (r_io_ld) begin
      w_merged = io_rdata;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_fwd_mask[b]) w_merged[8*b +: 8] = r_fwd_data[8*b +: 8];
      end
    end
  end

  assign ld_data_wb = load_extend(ld_code_wb, w_merged, rd_data_wb[1:0]);

endmodule
